// File: rtl/icache_fetch_align.sv
// icache_fetch_align: extracts a fetch packet of up to FETCH_WIDTH consecutive 32-bit
// instructions from an ICache hit line or from an in-flight refill. The refill line is
// assembled beat by beat for the data-RAM write-back.
// Optional feature macro: ICACHE_EARLY_RESTART_EN. When it is defined, the refill packet is
// forwarded as soon as the requested words have arrived. When it is undefined, the packet
// waits for the last beat.
module icache_fetch_align #(
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned BEAT_WORDS  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            hit_valid,
    input  logic [32*LINE_WORDS-1:0]        hit_line,
    input  logic [$clog2(LINE_WORDS)-1:0]   hit_offset,
    output logic                            hit_ready,
    input  logic                            refill_start,
    input  logic [$clog2(LINE_WORDS)-1:0]   refill_offset,
    input  logic                            refill_beat_valid,
    input  logic [32*BEAT_WORDS-1:0]        refill_beat_data,
    input  logic                            refill_beat_last,
    output logic [32*LINE_WORDS-1:0]        refill_line,
    output logic                            refill_done,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [32*FETCH_WIDTH-1:0]       out_inst,
    output logic [FETCH_WIDTH-1:0]          out_mask,
    output logic                            out_src
);

    localparam int unsigned OFS_W  = $clog2(LINE_WORDS);
    localparam int unsigned NBEATS = LINE_WORDS / BEAT_WORDS;
    localparam int unsigned BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned LINE_W = 32 * LINE_WORDS;
    localparam int unsigned BEAT_W = 32 * BEAT_WORDS;
    localparam int unsigned INST_W = 32 * FETCH_WIDTH;
    localparam int unsigned PKT_W  = INST_W + FETCH_WIDTH;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [OFS_W-1:0]  offset_q, offset_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              emitted_q, emitted_d;
    logic [LINE_W-1:0] refill_line_q, line_next;
    logic              refill_done_q, refill_done_d;
    logic              out_valid_q, out_valid_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [FETCH_WIDTH-1:0] out_mask_q, out_mask_d;
    logic              out_src_q, out_src_d;

    logic              free;
    logic              hit_acc;
    logic              beat_wr;
    logic              last_wr;
    logic              emit_cond;
    logic              emit;
    logic [PKT_W-1:0]  hit_pkt;
    logic [PKT_W-1:0]  refill_pkt;

    // Packet layout: {mask, inst}. Slots that fall past the end of the line are zero and
    // masked off. They do not wrap to the start of the line.
    function automatic logic [PKT_W-1:0] build_pkt(input logic [LINE_W-1:0] line,
                                                    input logic [OFS_W-1:0]  ofs);
        logic [PKT_W-1:0] p;
        p = '0;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            for (int j = 0; j < int'(LINE_WORDS); j++) begin
                if (int'(ofs) + i == j) begin
                    p[32*i +: 32]      = line[32*j +: 32];
                    p[INST_W + i]      = 1'b1;
                end
            end
        end
        return p;
    endfunction

    // Handshake and beat qualification
    always_comb begin
        free      = !out_valid_q || out_ready;
        hit_ready = !rst && (state_q == StIdle) && free;
        hit_acc   = hit_valid && hit_ready;
        beat_wr   = (state_q == StFill) && refill_beat_valid;
        last_wr   = beat_wr && refill_beat_last;
    end

    // Merge the incoming beat into the line so that a packet can be built in the same cycle
    always_comb begin
        line_next = refill_line_q;
        if (beat_wr) begin
            for (int b = 0; b < int'(NBEATS); b++) begin
                if (beat_cnt_q == BCNT_W'(b)) begin
                    line_next[b*BEAT_W +: BEAT_W] = refill_beat_data;
                end
            end
        end
    end

`ifdef ICACHE_EARLY_RESTART_EN
    logic [LINE_WORDS-1:0] bitmap_q, bitmap_d, bitmap_next;
    logic                  words_ready;

    // Track which words have landed and test whether the requested words are all present
    always_comb begin
        bitmap_next = bitmap_q;
        if (beat_wr) begin
            for (int b = 0; b < int'(NBEATS); b++) begin
                if (beat_cnt_q == BCNT_W'(b)) begin
                    bitmap_next[b*BEAT_WORDS +: BEAT_WORDS] = '1;
                end
            end
        end
        words_ready = 1'b1;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            for (int j = 0; j < int'(LINE_WORDS); j++) begin
                if ((int'(offset_q) + i == j) && !bitmap_next[j]) begin
                    words_ready = 1'b0;
                end
            end
        end
        bitmap_d = (state_q == StIdle && refill_start) ? '0 : bitmap_next;
        emit_cond = ((state_q == StFill) && words_ready) || (state_q == StDone);
    end

    // Word-valid bitmap register
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap_q <= '0;
        end else begin
            bitmap_q <= bitmap_d;
        end
    end
`else
    // Without early restart, the packet waits for the complete line
    always_comb begin
        emit_cond = last_wr || (state_q == StDone);
    end
`endif

    // Packet assembly and the single-emission gate for the refill packet
    always_comb begin
        hit_pkt    = build_pkt(hit_line, hit_offset);
        refill_pkt = build_pkt(line_next, offset_q);
        emit       = !emitted_q && emit_cond && free;
    end

    // Refill FSM next state
    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        beat_cnt_d    = beat_cnt_q;
        emitted_d     = emitted_q;
        refill_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (refill_start) begin
                    state_d    = StFill;
                    offset_d   = refill_offset;
                    beat_cnt_d = '0;
                    emitted_d  = 1'b0;
                end
            end
            StFill: begin
                if (emit) begin
                    emitted_d = 1'b1;
                end
                if (beat_wr) begin
                    beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                end
                // An early last beat still ends the refill; unwritten words keep old data
                if (last_wr) begin
                    refill_done_d = 1'b1;
                    state_d       = (emitted_q || emit) ? StIdle : StDone;
                end
            end
            StDone: begin
                if (emit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register: a hit has priority because hits and refill emission never overlap
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_mask_d  = out_mask_q;
        out_src_d   = out_src_q;
        if (hit_acc) begin
            out_valid_d = 1'b1;
            out_inst_d  = hit_pkt[INST_W-1:0];
            out_mask_d  = hit_pkt[PKT_W-1:INST_W];
            out_src_d   = 1'b0;
        end else if (emit) begin
            out_valid_d = 1'b1;
            out_inst_d  = refill_pkt[INST_W-1:0];
            out_mask_d  = refill_pkt[PKT_W-1:INST_W];
            out_src_d   = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            offset_q      <= '0;
            beat_cnt_q    <= '0;
            emitted_q     <= 1'b0;
            refill_line_q <= '0;
            refill_done_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_inst_q    <= '0;
            out_mask_q    <= '0;
            out_src_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            beat_cnt_q    <= beat_cnt_d;
            emitted_q     <= emitted_d;
            refill_line_q <= line_next;
            refill_done_q <= refill_done_d;
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            out_mask_q    <= out_mask_d;
            out_src_q     <= out_src_d;
        end
    end

    assign refill_line = refill_line_q;
    assign refill_done = refill_done_q;
    assign out_valid   = out_valid_q;
    assign out_inst    = out_inst_q;
    assign out_mask    = out_mask_q;
    assign out_src     = out_src_q;

endmodule

// File: tb/tb_icache_fetch_align.sv
// Directed bench for icache_fetch_align at default parameters (4-word line, 2-wide packet,
// 1-word beats). Hit vectors come from a table. Refill, backpressure and reset cases are
// hand-written sequences.
module tb_icache_fetch_align;

    logic         clk;
    logic         rst;
    logic         hit_valid;
    logic [127:0] hit_line;
    logic [1:0]   hit_offset;
    logic         hit_ready;
    logic         refill_start;
    logic [1:0]   refill_offset;
    logic         refill_beat_valid;
    logic [31:0]  refill_beat_data;
    logic         refill_beat_last;
    logic [127:0] refill_line;
    logic         refill_done;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_inst;
    logic [1:0]   out_mask;
    logic         out_src;

    int n_pass;
    int n_total;

`ifdef ICACHE_EARLY_RESTART_EN
    localparam int EMIT_BEAT = 2;
`else
    localparam int EMIT_BEAT = 3;
`endif

    icache_fetch_align #(
        .LINE_WORDS  (4),
        .FETCH_WIDTH (2),
        .BEAT_WORDS  (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .hit_valid         (hit_valid),
        .hit_line          (hit_line),
        .hit_offset        (hit_offset),
        .hit_ready         (hit_ready),
        .refill_start      (refill_start),
        .refill_offset     (refill_offset),
        .refill_beat_valid (refill_beat_valid),
        .refill_beat_data  (refill_beat_data),
        .refill_beat_last  (refill_beat_last),
        .refill_line       (refill_line),
        .refill_done       (refill_done),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_inst          (out_inst),
        .out_mask          (out_mask),
        .out_src           (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] line;
        logic [1:0]   ofs;
        logic [63:0]  inst;
        logic [1:0]   mask;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    localparam logic [127:0] L1 = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    localparam logic [127:0] L2 = {32'h2000_0033, 32'h2000_0022, 32'h2000_0011, 32'h2000_0000};

    initial begin
        n_pass = 0;
        n_total = 0;
        vecs[0] = '{L1, 2'd0, {32'h1000_0001, 32'h1000_0000}, 2'b11};
        vecs[1] = '{L1, 2'd1, {32'h1000_0002, 32'h1000_0001}, 2'b11};
        vecs[2] = '{L1, 2'd3, {32'h0000_0000, 32'h1000_0003}, 2'b01};
        vecs[3] = '{L2, 2'd2, {32'h2000_0033, 32'h2000_0022}, 2'b11};
        vecs[4] = '{L2, 2'd3, {32'h0000_0000, 32'h2000_0033}, 2'b01};
        vecs[5] = '{L2, 2'd0, {32'h2000_0011, 32'h2000_0000}, 2'b11};

        rst = 1'b1;
        hit_valid = 1'b0;
        hit_line = '0;
        hit_offset = '0;
        refill_start = 1'b0;
        refill_offset = '0;
        refill_beat_valid = 1'b0;
        refill_beat_data = '0;
        refill_beat_last = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state; out_ready high so only rst can hold hit_ready low
        out_ready = 1'b1;
        #1;
        chk("rst_hit_ready", hit_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_refill_done", refill_done, 0);
        chk("rst_refill_line", refill_line, 0);
        rst = 1'b0;

        // Back-to-back hits, one per cycle
        for (int v = 0; v < 6; v++) begin
            hit_valid = 1'b1;
            hit_line = vecs[v].line;
            hit_offset = vecs[v].ofs;
            #1;
            chk($sformatf("hit%0d_ready", v), hit_ready, 1);
            tick();
            chk($sformatf("hit%0d_valid", v), out_valid, 1);
            chk($sformatf("hit%0d_inst", v), out_inst, vecs[v].inst);
            chk($sformatf("hit%0d_mask", v), out_mask, vecs[v].mask);
            chk($sformatf("hit%0d_src", v), out_src, 0);
        end
        hit_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);

        // Backpressure: packet held while out_ready is low, then next hit taken same cycle
        hit_valid = 1'b1;
        hit_line = L1;
        hit_offset = 2'd0;
        out_ready = 1'b0;
        tick();
        hit_offset = 2'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_hit_ready", hit_ready, 0);
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_inst", out_inst, {32'h1000_0001, 32'h1000_0000});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", hit_ready, 1);
        tick();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_inst", out_inst, {32'h1000_0002, 32'h1000_0001});
        chk("bp_next_mask", out_mask, 2'b11);
        hit_valid = 1'b0;
        tick();
        chk("bp_drain", out_valid, 0);

        // Refill at offset 1, beats 0..3 on consecutive cycles
        refill_start = 1'b1;
        refill_offset = 2'd1;
        tick();
        refill_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            refill_beat_valid = 1'b1;
            refill_beat_data = 32'hA000_0000 + k;
            refill_beat_last = (k == 3);
            tick();
            chk($sformatf("rf_beat%0d_valid", k), out_valid, (k == EMIT_BEAT));
            chk($sformatf("rf_beat%0d_done", k), refill_done, (k == 3));
            if (k == EMIT_BEAT) begin
                chk("rf_inst", out_inst, {32'hA000_0002, 32'hA000_0001});
                chk("rf_mask", out_mask, 2'b11);
                chk("rf_src", out_src, 1);
            end
        end
        chk("rf_line", refill_line,
            {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
        refill_beat_valid = 1'b0;
        refill_beat_last = 1'b0;
        tick();
        chk("rf_done_pulse", refill_done, 0);
        chk("rf_after_valid", out_valid, 0);
        chk("rf_line_stable", refill_line,
            {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
        chk("rf_idle_ready", hit_ready, 1);

        // Refill while the output register is stalled: FSM parks in DONE
        hit_valid = 1'b1;
        hit_line = L1;
        hit_offset = 2'd2;
        out_ready = 1'b0;
        tick();
        hit_valid = 1'b0;
        refill_start = 1'b1;
        refill_offset = 2'd3;
        tick();
        refill_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            refill_beat_valid = 1'b1;
            refill_beat_data = 32'hB000_0000 + k;
            refill_beat_last = (k == 3);
            tick();
        end
        refill_beat_valid = 1'b0;
        refill_beat_last = 1'b0;
        chk("st_done", refill_done, 1);
        chk("st_hold_src", out_src, 0);
        chk("st_hold_inst", out_inst, {32'h1000_0003, 32'h1000_0002});
        tick();
        tick();
        chk("st_done_hit_ready", hit_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("st_release_hit_ready", hit_ready, 0);
        tick();
        chk("st_emit_valid", out_valid, 1);
        chk("st_emit_src", out_src, 1);
        chk("st_emit_inst", out_inst, {32'h0000_0000, 32'hB000_0003});
        chk("st_emit_mask", out_mask, 2'b01);
        chk("st_back_idle", hit_ready, 1);
        tick();
        chk("st_once_a", out_valid, 0);
        tick();
        chk("st_once_b", out_valid, 0);

        // Reset in the middle of a refill
        refill_start = 1'b1;
        refill_offset = 2'd0;
        tick();
        refill_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            refill_beat_valid = 1'b1;
            refill_beat_data = 32'hC000_0000 + k;
            tick();
        end
        refill_beat_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_hit_ready", hit_ready, 0);
        tick();
        chk("mr_valid", out_valid, 0);
        chk("mr_done", refill_done, 0);
        chk("mr_line", refill_line, 0);
        rst = 1'b0;
        hit_valid = 1'b1;
        hit_line = L1;
        hit_offset = 2'd1;
        #1;
        chk("mr_hit_ready_after", hit_ready, 1);
        tick();
        chk("mr_hit_valid", out_valid, 1);
        chk("mr_hit_inst", out_inst, {32'h1000_0002, 32'h1000_0001});
        chk("mr_hit_src", out_src, 0);
        hit_valid = 1'b0;
        // Stray beats in IDLE must be ignored
        refill_beat_valid = 1'b1;
        refill_beat_data = 32'hDEAD_BEEF;
        refill_beat_last = 1'b1;
        tick();
        refill_beat_valid = 1'b0;
        refill_beat_last = 1'b0;
        tick();
        chk("stray_done", refill_done, 0);
        chk("stray_line", refill_line, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
